fc_layer: RTL

Fully-connected (dense) stage directly downstream of the 2×2 max-pool stage. Triggered by the pool stage's completion pulse, it reads the IN_LEN pooled int8 activations from the feature RAM and weights from a weight ROM, and performs a signed multiply-accumulate per output neuron. It adds a per-neuron bias, requantizes to int8 (shift, optional ReLU, saturate) and writes OUT_LEN results to the output RAM. It signals completion with a one-cycle pulse.

---
 rtl/fc_pkg.sv | 27 ++
 rtl/fc_layer_if.sv | 32 +++
 rtl/fc_mac.sv | 33 +++
 rtl/fc_layer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected stage.
//   fc_state_t : FSM state encoding
//   ACC_W      : accumulator width (worst case 1600*128*128 fits easily)
//   sat_int8   : clamp a signed accumulator-width value to int8
package fc_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_POST,
    ST_WRITE,
    ST_DONE
  } fc_state_t;

  function automatic logic signed [7:0] sat_int8(input logic signed [ACC_W-1:0] v);
    if (v > 127) begin
      return 8'h7f;
    end else if (v < -128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/fc_layer_if.sv
// Memory/handshake bundle of the fully-connected stage.
//   master : the fc_layer side (drives addresses, enables, results, end_fc)
//   slave  : the memory / sequencer side (drives start_fc and read data)
// Read data (act_data_r, w_data, b_data) is expected one cycle after address.
interface fc_layer_if;
  logic               start_fc;
  logic               end_fc;
  logic [15:0]        act_addr_r;
  logic               act_en_r;
  logic signed [7:0]  act_data_r;
  logic [15:0]        w_addr;
  logic               w_en;
  logic signed [7:0]  w_data;
  logic [3:0]         b_addr;
  logic signed [15:0] b_data;
  logic [15:0]        ram_addr_w;
  logic signed [7:0]  ram_data_w;
  logic               ram_en;
  logic               ram_wea;

  modport master (
    input  start_fc, act_data_r, w_data, b_data,
    output end_fc, act_addr_r, act_en_r, w_addr, w_en, b_addr,
           ram_addr_w, ram_data_w, ram_en, ram_wea
  );

  modport slave (
    output start_fc, act_data_r, w_data, b_data,
    input  end_fc, act_addr_r, act_en_r, w_addr, w_en, b_addr,
           ram_addr_w, ram_data_w, ram_en, ram_wea
  );
endinterface

// File: rtl/fc_mac.sv
// Signed 8x8 multiply-accumulate into an ACC_W-bit register.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of the accumulator (wins over en)
//   en         : add a*b into the accumulator this cycle
//   a, b       : signed int8 operands
//   acc        : signed accumulator
module fc_mac
  import fc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [7:0]       a,
  input  logic signed [7:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [15:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-16){prod[15]}}, prod};
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected stage: for each output neuron j, accumulates
// act[i]*w[j*IN_LEN+i] over IN_LEN inputs, adds bias[j], shifts right by
// SHIFT (floor), optionally applies ReLU, saturates to int8 and writes the
// result to OUT_BASE+j. Pulses end_fc once all OUT_LEN neurons are written.
//   clk, rst_n : clock, async active-low reset
//   bus        : fc_layer_if.master (start/done, act RAM, weight ROM,
//                bias ROM, output RAM ports)
//
// state | meaning
// IDLE  | waiting for start_fc, counters cleared
// MAC   | IN_LEN reads issued, IN_LEN+1 cycles (last cycle only accumulates)
// POST  | bias add, shift, ReLU, saturate into ram_data_w
// WRITE | one output RAM write, advance to next neuron or finish
// DONE  | one-cycle end_fc pulse
module fc_layer
  import fc_pkg::*;
#(
  parameter int IN_LEN   = 1600,
  parameter int OUT_LEN  = 10,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 0,
  parameter int SHIFT    = 8,
  parameter int RELU     = 0
) (
  input logic        clk,
  input logic        rst_n,
  fc_layer_if.master bus
);

  fc_state_t state_q, state_d;

  logic [15:0] i_q;
  logic [15:0] w_q;
  logic [3:0]  j_q;
  logic        rd_q;
  logic        rd_en;
  logic        last_mac;
  logic        last_neuron;
  logic        mac_clr;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] post_val;

  assign rd_en       = (state_q == ST_MAC) && (i_q < 16'(IN_LEN));
  assign last_mac    = (i_q == 16'(IN_LEN));
  assign last_neuron = (j_q == 4'(OUT_LEN - 1));
  // Clearing in IDLE as well guarantees a fresh accumulator for every run.
  assign mac_clr     = (state_q == ST_IDLE) || (state_q == ST_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start_fc) state_d = ST_MAC;
      ST_MAC:   if (last_mac) state_d = ST_POST;
      ST_POST:  state_d = ST_WRITE;
      ST_WRITE: state_d = last_neuron ? ST_DONE : ST_MAC;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  fc_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (rd_q),
    .a     (bus.act_data_r),
    .b     (bus.w_data),
    .acc   (acc)
  );

  always_comb begin
    biased   = acc + {{(ACC_W-16){bus.b_data[15]}}, bus.b_data};
    shifted  = biased >>> SHIFT;
    post_val = shifted;
    if ((RELU != 0) && (shifted < 0)) begin
      post_val = '0;
    end
  end

  // w_q walks the weight ROM linearly: it equals j*IN_LEN+i at every read
  // without needing a multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q            <= '0;
      w_q            <= '0;
      j_q            <= '0;
      rd_q           <= 1'b0;
      bus.ram_data_w <= '0;
      bus.ram_addr_w <= '0;
    end else begin
      rd_q <= rd_en;
      case (state_q)
        ST_IDLE: begin
          i_q <= '0;
          w_q <= '0;
          j_q <= '0;
        end
        ST_MAC: begin
          if (rd_en) begin
            i_q <= i_q + 16'd1;
            w_q <= w_q + 16'd1;
          end
        end
        ST_POST: begin
          bus.ram_data_w <= sat_int8(post_val);
          bus.ram_addr_w <= 16'(OUT_BASE) + {12'd0, j_q};
        end
        ST_WRITE: begin
          i_q <= '0;
          if (!last_neuron) begin
            j_q <= j_q + 4'd1;
          end
        end
        ST_DONE: begin
          j_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.act_en_r   = rd_en;
  assign bus.w_en       = rd_en;
  assign bus.act_addr_r = rd_en ? (16'(IN_BASE) + i_q) : '0;
  assign bus.w_addr     = rd_en ? w_q : '0;
  assign bus.b_addr     = j_q;
  assign bus.ram_en     = (state_q == ST_WRITE);
  assign bus.ram_wea    = (state_q == ST_WRITE);
  assign bus.end_fc     = (state_q == ST_DONE);

endmodule
